execute_stage: RTL and testbench

Y86-64 pipelined execute stage, directly downstream of the register file / decode stage.
- Latches decode outputs (valA, valB, valC, dstE, dstM and instruction fields) into the E pipeline register.
- Computes valE in the ALU, maintains the condition-code (CC) register, evaluates jump/cmov conditions and drives the M pipeline register.
- Exposes combinational e_dstE/e_valE for forwarding back into decode.

---
 rtl/execute_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// ============================================================================
//  Module      : execute_stage
//  Description : Y86-64 pipelined execute stage with E/M pipeline registers,
//                ALU, condition-code register and jump/cmov evaluation.
//                Optional macro EXEC_ALU_EXT_EN adds OPQ ifun 4 (OR) and
//                ifun 5 (ANDN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage #(
    parameter int W          = 64,
    parameter int STACK_STEP = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         E_stall,
    input  logic         E_bubble,
    input  logic         M_bubble,
    input  logic [3:0]   D_stat,
    input  logic [3:0]   D_icode,
    input  logic [3:0]   D_ifun,
    input  logic [W-1:0] D_valC,
    input  logic [W-1:0] D_valA,
    input  logic [W-1:0] D_valB,
    input  logic [3:0]   D_dstE,
    input  logic [3:0]   D_dstM,
    input  logic [3:0]   m_stat,
    input  logic [3:0]   W_stat,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [3:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic [2:0]   cc_out
);

    localparam logic [3:0] c_STAT_AOK = 4'h1;
    localparam logic [3:0] c_STAT_HLT = 4'h2;
    localparam logic [3:0] c_STAT_ADR = 4'h3;
    localparam logic [3:0] c_STAT_INS = 4'h4;

    localparam logic [3:0] c_I_NOP    = 4'h1;
    localparam logic [3:0] c_I_RRMOVQ = 4'h2;
    localparam logic [3:0] c_I_IRMOVQ = 4'h3;
    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;

    localparam logic [3:0] c_ALU_ADD  = 4'h0;
    localparam logic [3:0] c_ALU_SUB  = 4'h1;
    localparam logic [3:0] c_ALU_AND  = 4'h2;
    localparam logic [3:0] c_ALU_XOR  = 4'h3;
`ifdef EXEC_ALU_EXT_EN
    localparam logic [3:0] c_ALU_OR   = 4'h4;
    localparam logic [3:0] c_ALU_ANDN = 4'h5;
`endif

    localparam logic [3:0]   c_REG_NONE = 4'hF;
    localparam logic [W-1:0] c_STEP     = W'(STACK_STEP);

    // E pipeline register
    logic [3:0]   r_eStat;
    logic [3:0]   r_eIcode;
    logic [3:0]   r_eIfun;
    logic [W-1:0] r_eValC;
    logic [W-1:0] r_eValA;
    logic [W-1:0] r_eValB;
    logic [3:0]   r_eDstE;
    logic [3:0]   r_eDstM;

    // M pipeline register
    logic [3:0]   r_mStat;
    logic [3:0]   r_mIcode;
    logic         r_mCnd;
    logic [W-1:0] r_mValE;
    logic [W-1:0] r_mValA;
    logic [3:0]   r_mDstE;
    logic [3:0]   r_mDstM;

    // Condition codes
    logic r_zf;
    logic r_sf;
    logic r_of;

    logic [W-1:0] w_aluA;
    logic [W-1:0] w_aluB;
    logic [3:0]   w_aluFun;
    logic [W-1:0] w_valE;
    logic         w_of;
    logic         w_zf;
    logic         w_sf;
    logic         w_setCc;
    logic         w_cond;
    logic         w_cnd;
    logic [3:0]   w_dstE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_eStat  <= c_STAT_AOK;
            r_eIcode <= c_I_NOP;
            r_eIfun  <= 4'h0;
            r_eValC  <= '0;
            r_eValA  <= '0;
            r_eValB  <= '0;
            r_eDstE  <= c_REG_NONE;
            r_eDstM  <= c_REG_NONE;
        end else if (E_bubble) begin
            r_eStat  <= c_STAT_AOK;
            r_eIcode <= c_I_NOP;
            r_eIfun  <= 4'h0;
            r_eValC  <= '0;
            r_eValA  <= '0;
            r_eValB  <= '0;
            r_eDstE  <= c_REG_NONE;
            r_eDstM  <= c_REG_NONE;
        end else if (!E_stall) begin
            r_eStat  <= D_stat;
            r_eIcode <= D_icode;
            r_eIfun  <= D_ifun;
            r_eValC  <= D_valC;
            r_eValA  <= D_valA;
            r_eValB  <= D_valB;
            r_eDstE  <= D_dstE;
            r_eDstM  <= D_dstM;
        end
    end

    always_comb begin
        w_aluA = '0;
        case (r_eIcode)
            c_I_RRMOVQ, c_I_OPQ:                w_aluA = r_eValA;
            c_I_IRMOVQ, c_I_RMMOVQ, c_I_MRMOVQ: w_aluA = r_eValC;
            c_I_CALL, c_I_PUSHQ:                w_aluA = -c_STEP;
            c_I_RET, c_I_POPQ:                  w_aluA = c_STEP;
            default:                            w_aluA = '0;
        endcase
    end

    always_comb begin
        w_aluB = '0;
        case (r_eIcode)
            c_I_RMMOVQ, c_I_MRMOVQ, c_I_OPQ, c_I_CALL,
            c_I_RET, c_I_PUSHQ, c_I_POPQ:       w_aluB = r_eValB;
            default:                            w_aluB = '0;
        endcase
    end

    assign w_aluFun = (r_eIcode == c_I_OPQ) ? r_eIfun : c_ALU_ADD;

    // Undefined OPQ functions yield zero with OF clear, so CC still sees ZF=1
    always_comb begin
        w_valE = '0;
        w_of   = 1'b0;
        case (w_aluFun)
            c_ALU_ADD: begin
                w_valE = w_aluB + w_aluA;
                w_of   = (w_aluA[W-1] == w_aluB[W-1]) && (w_valE[W-1] != w_aluA[W-1]);
            end
            c_ALU_SUB: begin
                w_valE = w_aluB - w_aluA;
                w_of   = (w_aluA[W-1] != w_aluB[W-1]) && (w_valE[W-1] != w_aluB[W-1]);
            end
            c_ALU_AND: w_valE = w_aluB & w_aluA;
            c_ALU_XOR: w_valE = w_aluB ^ w_aluA;
`ifdef EXEC_ALU_EXT_EN
            c_ALU_OR:   w_valE = w_aluB | w_aluA;
            c_ALU_ANDN: w_valE = w_aluB & ~w_aluA;
`endif
            default: begin
                w_valE = '0;
                w_of   = 1'b0;
            end
        endcase
    end

    assign w_zf = (w_valE == '0);
    assign w_sf = w_valE[W-1];

    // Suppress CC writes once an exception is in flight downstream
    assign w_setCc = (r_eIcode == c_I_OPQ)
                   && (m_stat != c_STAT_HLT) && (m_stat != c_STAT_ADR) && (m_stat != c_STAT_INS)
                   && (W_stat != c_STAT_HLT) && (W_stat != c_STAT_ADR) && (W_stat != c_STAT_INS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_setCc) begin
            r_zf <= w_zf;
            r_sf <= w_sf;
            r_of <= w_of;
        end
    end

    always_comb begin
        w_cond = 1'b0;
        case (r_eIfun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = (r_sf ^ r_of) | r_zf;
            4'h2:    w_cond = r_sf ^ r_of;
            4'h3:    w_cond = r_zf;
            4'h4:    w_cond = ~r_zf;
            4'h5:    w_cond = ~(r_sf ^ r_of);
            4'h6:    w_cond = ~(r_sf ^ r_of) & ~r_zf;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_cnd  = ((r_eIcode == c_I_JXX) || (r_eIcode == c_I_RRMOVQ)) ? w_cond : 1'b0;
    assign w_dstE = ((r_eIcode == c_I_RRMOVQ) && !w_cnd) ? c_REG_NONE : r_eDstE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mStat  <= c_STAT_AOK;
            r_mIcode <= c_I_NOP;
            r_mCnd   <= 1'b0;
            r_mValE  <= '0;
            r_mValA  <= '0;
            r_mDstE  <= c_REG_NONE;
            r_mDstM  <= c_REG_NONE;
        end else if (M_bubble) begin
            r_mStat  <= c_STAT_AOK;
            r_mIcode <= c_I_NOP;
            r_mCnd   <= 1'b0;
            r_mValE  <= '0;
            r_mValA  <= '0;
            r_mDstE  <= c_REG_NONE;
            r_mDstM  <= c_REG_NONE;
        end else begin
            r_mStat  <= r_eStat;
            r_mIcode <= r_eIcode;
            r_mCnd   <= w_cnd;
            r_mValE  <= w_valE;
            r_mValA  <= r_eValA;
            r_mDstE  <= w_dstE;
            r_mDstM  <= r_eDstM;
        end
    end

    assign e_valE  = w_valE;
    assign e_dstE  = w_dstE;
    assign e_Cnd   = w_cnd;
    assign M_stat  = r_mStat;
    assign M_icode = r_mIcode;
    assign M_Cnd   = r_mCnd;
    assign M_valE  = r_mValE;
    assign M_valA  = r_mValA;
    assign M_dstE  = r_mDstE;
    assign M_dstM  = r_mDstM;
    assign cc_out  = {r_zf, r_sf, r_of};

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Scoreboard bench for execute_stage with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage;

    localparam int W = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         E_stall = 1'b0;
    logic         E_bubble = 1'b0;
    logic         M_bubble = 1'b0;
    logic [3:0]   D_stat = 4'h1;
    logic [3:0]   D_icode = 4'h1;
    logic [3:0]   D_ifun = 4'h0;
    logic [W-1:0] D_valC = '0;
    logic [W-1:0] D_valA = '0;
    logic [W-1:0] D_valB = '0;
    logic [3:0]   D_dstE = 4'hF;
    logic [3:0]   D_dstM = 4'hF;
    logic [3:0]   m_stat = 4'h1;
    logic [3:0]   W_stat = 4'h1;
    logic [W-1:0] e_valE;
    logic [3:0]   e_dstE;
    logic         e_Cnd;
    logic [3:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_Cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;
    logic [2:0]   cc_out;

    execute_stage #(.W(W), .STACK_STEP(8)) dut (
        .clock(clock), .reset(reset),
        .E_stall(E_stall), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_valC(D_valC), .D_valA(D_valA), .D_valB(D_valB),
        .D_dstE(D_dstE), .D_dstM(D_dstM),
        .m_stat(m_stat), .W_stat(W_stat),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc_out(cc_out)
    );

    always #5 clock = ~clock;

    localparam int c_S_EVALE  = 0;
    localparam int c_S_EDSTE  = 1;
    localparam int c_S_ECND   = 2;
    localparam int c_S_CC     = 3;
    localparam int c_S_MICODE = 4;
    localparam int c_S_MVALE  = 5;
    localparam int c_S_MDSTE  = 6;
    localparam int c_S_MCND   = 7;
    localparam int c_S_MSTAT  = 8;
    localparam int c_S_MVALA  = 9;
    localparam int c_S_MDSTM  = 10;

    typedef struct {
        int          due;
        string       name;
        int          sig;
        logic [63:0] exp;
    } chk_t;

    chk_t        q[$];
    chk_t        monCur;
    logic [63:0] monAct;
    int          cyc = 0;
    int          nChecks = 0;
    int          nFails = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [63:0] getSig(input int s);
        case (s)
            c_S_EVALE:  return e_valE;
            c_S_EDSTE:  return 64'(e_dstE);
            c_S_ECND:   return 64'(e_Cnd);
            c_S_CC:     return 64'(cc_out);
            c_S_MICODE: return 64'(M_icode);
            c_S_MVALE:  return M_valE;
            c_S_MDSTE:  return 64'(M_dstE);
            c_S_MCND:   return 64'(M_Cnd);
            c_S_MSTAT:  return 64'(M_stat);
            c_S_MVALA:  return M_valA;
            c_S_MDSTM:  return 64'(M_dstM);
            default:    return 64'hDEAD;
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            monCur = q.pop_front();
            nChecks++;
            if (monCur.due < cyc) begin
                nFails++;
                $display("FAIL %s: sample cycle %0d missed (now %0d)", monCur.name, monCur.due, cyc);
            end else begin
                monAct = getSig(monCur.sig);
                if (monAct !== monCur.exp) begin
                    nFails++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", monCur.name, monAct, monCur.exp, cyc);
                end
            end
        end
    end

    task automatic chk(input int dt, input string name, input int sig, input logic [63:0] e);
        chk_t c;
        c.due  = cyc + dt;
        c.name = name;
        c.sig  = sig;
        c.exp  = e;
        q.push_back(c);
    endtask

    // Presents one instruction to D; it sits in E for the cycle after return
    task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [3:0] de, input logic [3:0] dm);
        D_stat  = 4'h1;
        D_icode = ic;
        D_ifun  = fn;
        D_valC  = vc;
        D_valA  = va;
        D_valB  = vb;
        D_dstE  = de;
        D_dstM  = dm;
        @(posedge clock) #1;
    endtask

    initial begin
        int waitCnt;
        logic [63:0] extExp;

        // Power-on reset values
        @(posedge clock) #1;
        chk(0, "rst_M_icode", c_S_MICODE, 64'h1);
        chk(0, "rst_M_dstE", c_S_MDSTE, 64'hF);
        chk(0, "rst_cc", c_S_CC, 64'h4);
        chk(0, "rst_M_stat", c_S_MSTAT, 64'h1);
        @(negedge clock) #1;
        reset = 1'b0;

        // SUB overflow
        issue(4'h6, 4'h1, 64'h0, 64'h1, 64'h8000_0000_0000_0000, 4'h0, 4'hF);
        chk(0, "sub_valE", c_S_EVALE, 64'h7FFF_FFFF_FFFF_FFFF);
        chk(0, "sub_dstE", c_S_EDSTE, 64'h0);
        chk(0, "sub_cnd", c_S_ECND, 64'h0);
        chk(1, "sub_cc", c_S_CC, 64'h1);
        chk(1, "sub_M_valE", c_S_MVALE, 64'h7FFF_FFFF_FFFF_FFFF);
        chk(1, "sub_M_icode", c_S_MICODE, 64'h6);
        chk(1, "sub_M_valA", c_S_MVALA, 64'h1);

        // IRMOVQ, ADD to zero, then cmove / cmovne
        issue(4'h3, 4'h0, 64'h5, 64'h0, 64'h0, 4'h3, 4'hF);
        chk(0, "irmov_valE", c_S_EVALE, 64'h5);
        chk(0, "irmov_dstE", c_S_EDSTE, 64'h3);
        chk(1, "irmov_cc", c_S_CC, 64'h1);
        issue(4'h6, 4'h0, 64'h0, 64'h5, 64'hFFFF_FFFF_FFFF_FFFB, 4'h4, 4'hF);
        chk(0, "addz_valE", c_S_EVALE, 64'h0);
        chk(1, "addz_cc", c_S_CC, 64'h4);
        issue(4'h2, 4'h3, 64'h0, 64'h1234, 64'h0, 4'h0, 4'hF);
        chk(0, "cmove_cnd", c_S_ECND, 64'h1);
        chk(0, "cmove_dstE", c_S_EDSTE, 64'h0);
        chk(0, "cmove_valE", c_S_EVALE, 64'h1234);
        chk(1, "cmove_M_cnd", c_S_MCND, 64'h1);
        issue(4'h2, 4'h4, 64'h0, 64'h1234, 64'h0, 4'h0, 4'hF);
        chk(0, "cmovne_cnd", c_S_ECND, 64'h0);
        chk(0, "cmovne_dstE", c_S_EDSTE, 64'hF);
        chk(1, "cmovne_M_dstE", c_S_MDSTE, 64'hF);
        issue(4'h7, 4'h1, 64'h400, 64'h0, 64'h0, 4'hF, 4'hF);
        chk(0, "jle_cnd", c_S_ECND, 64'h1);
        issue(4'h7, 4'h2, 64'h400, 64'h0, 64'h0, 4'hF, 4'hF);
        chk(0, "jl_cnd", c_S_ECND, 64'h0);

        // Stack adjust without CC effect
        issue(4'hA, 4'h0, 64'h0, 64'h55, 64'h100, 4'h4, 4'hF);
        chk(0, "push_valE", c_S_EVALE, 64'hF8);
        chk(1, "push_cc", c_S_CC, 64'h4);
        chk(1, "push_M_valA", c_S_MVALA, 64'h55);
        issue(4'hB, 4'h0, 64'h0, 64'h100, 64'h100, 4'h4, 4'h0);
        chk(0, "pop_valE", c_S_EVALE, 64'h108);
        chk(1, "pop_cc", c_S_CC, 64'h4);
        chk(1, "pop_M_dstM", c_S_MDSTM, 64'h0);

        // CC write suppressed by downstream exceptions
        issue(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2, 4'hF);
        chk(0, "addadr_valE", c_S_EVALE, 64'h2);
        m_stat = 4'h3;
        issue(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        chk(0, "mstat_adr_cc", c_S_CC, 64'h4);
        m_stat = 4'h1;
        issue(4'h6, 4'h1, 64'h0, 64'h1, 64'h0, 4'h2, 4'hF);
        chk(0, "subhlt_valE", c_S_EVALE, 64'hFFFF_FFFF_FFFF_FFFF);
        W_stat = 4'h2;
        issue(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        chk(0, "wstat_hlt_cc", c_S_CC, 64'h4);
        W_stat = 4'h1;

        // Logic ops and out-of-range function codes
        issue(4'h6, 4'h3, 64'h0, 64'hFF, 64'h0F, 4'h2, 4'hF);
        chk(0, "xor_valE", c_S_EVALE, 64'hF0);
        chk(1, "xor_cc", c_S_CC, 64'h0);
`ifdef EXEC_ALU_EXT_EN
        extExp = 64'hFF;
`else
        extExp = 64'h0;
`endif
        issue(4'h6, 4'h4, 64'h0, 64'h0F, 64'hF0, 4'h2, 4'hF);
        chk(0, "opq4_valE", c_S_EVALE, extExp);
        chk(1, "opq4_cc", c_S_CC, (extExp == 64'h0) ? 64'h4 : 64'h0);
        issue(4'h6, 4'h6, 64'h0, 64'h7, 64'h9, 4'h2, 4'hF);
        chk(0, "opq6_valE", c_S_EVALE, 64'h0);
        chk(1, "opq6_cc", c_S_CC, 64'h4);

        // Stall for two cycles, then bubble wins over stall
        issue(4'h6, 4'h0, 64'h0, 64'h2, 64'h3, 4'h5, 4'hF);
        chk(0, "stall0_valE", c_S_EVALE, 64'h5);
        chk(1, "stall_cc", c_S_CC, 64'h0);
        E_stall = 1'b1;
        issue(4'h3, 4'h0, 64'h77, 64'h0, 64'h0, 4'h1, 4'hF);
        chk(0, "stall1_valE", c_S_EVALE, 64'h5);
        issue(4'h3, 4'h0, 64'h77, 64'h0, 64'h0, 4'h1, 4'hF);
        chk(0, "stall2_valE", c_S_EVALE, 64'h5);
        chk(0, "stall2_M_icode", c_S_MICODE, 64'h6);
        E_bubble = 1'b1;
        issue(4'h3, 4'h0, 64'h77, 64'h0, 64'h0, 4'h1, 4'hF);
        chk(0, "bubble_valE", c_S_EVALE, 64'h0);
        chk(0, "bubble_dstE", c_S_EDSTE, 64'hF);
        chk(0, "bubble_M_icode_prev", c_S_MICODE, 64'h6);
        chk(1, "bubble_M_icode", c_S_MICODE, 64'h1);
        E_stall  = 1'b0;
        E_bubble = 1'b0;

        // M bubble
        issue(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2, 4'hF);
        M_bubble = 1'b1;
        issue(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        chk(0, "mbub_M_icode", c_S_MICODE, 64'h1);
        chk(0, "mbub_M_valE", c_S_MVALE, 64'h0);
        M_bubble = 1'b0;

        // Asynchronous reset with an OPQ in E and M
        issue(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2, 4'hF);
        issue(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h3, 4'hF);
        chk(0, "arst_M_icode", c_S_MICODE, 64'h1);
        chk(0, "arst_M_dstE", c_S_MDSTE, 64'hF);
        chk(0, "arst_cc", c_S_CC, 64'h4);
        chk(0, "arst_valE", c_S_EVALE, 64'h0);
        chk(0, "arst_dstE", c_S_EDSTE, 64'hF);
        #1 reset = 1'b1;
        @(negedge clock) #1;
        reset = 1'b0;

        waitCnt = 0;
        while (q.size() > 0 && waitCnt < 20) begin
            @(posedge clock);
            waitCnt++;
        end
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never sampled, expected 0", q.size());
            nChecks += q.size();
            nFails  += q.size();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
